// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the round-robin serial-add controller.
package serial_add_pkg;

  localparam int SA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sa_state_t;

endpackage

// File: rtl/serial_adder_core.sv
// One-bit full adder with a registered carry; clr wins over en.
module serial_adder_core (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic x,
  input  logic y,
  output logic s,
  output logic c_next,
  output logic c_q
);

  assign s      = x ^ y ^ c_q;
  assign c_next = (x & y) | (x & c_q) | (y & c_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= 1'b0;
    end else if (clr) begin
      c_q <= 1'b0;
    end else if (en) begin
      c_q <= c_next;
    end
  end

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter that owns the shared serial adder and streams the
// granted operand pair through it LSB-first, returning sum and carry-out.
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int N = SA_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic [1:0]   ack,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  sa_state_t      state_q, state_d;
  logic           last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   s_q, s_d;
  logic           cout_q, cout_d;
  logic [1:0]     ack_q, ack_d;

  logic winner;
  logic adderClr, adderEn;
  logic sBit, cNext;
  logic unused_carry;

  serial_adder_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (adderClr),
    .en     (adderEn),
    .x      (a_q[0]),
    .y      (b_q[0]),
    .s      (sBit),
    .c_next (cNext),
    .c_q    (unused_carry)
  );

  // On a tie the requester that was not served last wins.
  assign winner = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    cout_d   = cout_q;
    ack_d    = 2'b00;
    adderClr = 1'b0;
    adderEn  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          adderClr = 1'b1;
          a_d      = winner ? a1 : a0;
          b_d      = winner ? b1 : b0;
          cnt_d    = '0;
          last_d   = winner;
          ack_d    = winner ? 2'b10 : 2'b01;
          state_d  = RUN;
        end
      end
      RUN: begin
        adderEn = 1'b1;
        s_d     = {sBit, s_q[N-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cout_d  = cNext;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ack_q   <= ack_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = last_q;
  assign sum     = s_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed self-checking bench for serial_add_arbiter with N=8.
module tb_serial_add_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic [1:0]   req;
  logic [N-1:0] a0, b0, a1, b1;
  logic [1:0]   ack;
  logic         busy, done, done_id, cout;
  logic [N-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_add_arbiter #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum),
    .cout    (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle just past it so outputs are stable.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset = 1'b1;
    req   = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cycles++;
      if (done) break;
    end
    if (!done) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic id, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [N-1:0] expSum,
                               input logic expCout, input string tag);
    int c;
    if (id) begin a1 = a; b1 = b; end
    else    begin a0 = a; b0 = b; end
    req = id ? 2'b10 : 2'b01;
    tick();
    checkOutput({tag, "_ack"}, 32'(ack), id ? 32'd2 : 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    req = 2'b00;
    waitDone(c);
    checkOutput({tag, "_latency"}, 32'(c), 32'(N));
    checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
    checkOutput({tag, "_id"}, 32'(done_id), 32'(id));
    tick();
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int c;
    int doneSeen;
    reset = 1'b0;
    req   = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    doReset();
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_doneId", 32'(done_id), 32'd1);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);

    applyStimulus(1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, "t1");

    applyStimulus(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, "t2a");
    applyStimulus(1'b0, 8'h80, 8'h7F, 8'hFF, 1'b0, "t2b");

    // Simultaneous requests after reset: requester 0 first, then 1.
    doReset();
    a0 = 8'h10; b0 = 8'h20; a1 = 8'h80; b1 = 8'h80;
    req = 2'b11;
    tick();
    checkOutput("t3_ack0", 32'(ack), 32'd1);
    req = 2'b10;
    waitDone(c);
    checkOutput("t3_sum0", 32'(sum), 32'h30);
    checkOutput("t3_cout0", 32'(cout), 32'd0);
    checkOutput("t3_id0", 32'(done_id), 32'd0);
    tick();
    checkOutput("t3_gapIdle", 32'(busy), 32'd0);
    tick();
    checkOutput("t3_ack1", 32'(ack), 32'd2);
    req = 2'b00;
    waitDone(c);
    checkOutput("t3_doneSpacing", 32'(c + 2), 32'd10);
    checkOutput("t3_sum1", 32'(sum), 32'h00);
    checkOutput("t3_cout1", 32'(cout), 32'd1);
    checkOutput("t3_id1", 32'(done_id), 32'd1);
    tick();

    // Continuous 11 requests alternate grants with one idle cycle between.
    doReset();
    a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("t4_ack", 32'(ack), (k % 2 == 1) ? 32'd2 : 32'd1);
      waitDone(c);
      checkOutput("t4_sum", 32'(sum), (k % 2 == 1) ? 32'd4 : 32'd2);
      checkOutput("t4_id", 32'(done_id), 32'(k % 2));
      tick();
      checkOutput("t4_gapBusy", 32'(busy), 32'd0);
      checkOutput("t4_gapAck", 32'(ack), 32'd0);
    end
    req = 2'b00;
    tick();

    // Reset during the fourth RUN cycle aborts the add.
    a0 = 8'hAA; b0 = 8'h55;
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    tick();
    checkOutput("t5_midRunBusy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_busyAfterRst", 32'(busy), 32'd0);
    checkOutput("t5_doneIdAfterRst", 32'(done_id), 32'd1);
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("t5_noDone", 32'(doneSeen), 32'd0);
    applyStimulus(1'b1, 8'h01, 8'h01, 8'h02, 1'b0, "t5b");
    a0 = 8'h03; b0 = 8'h04; a1 = 8'h05; b1 = 8'h06;
    req = 2'b11;
    tick();
    checkOutput("t5_rrAck", 32'(ack), 32'd1);
    req = 2'b00;
    waitDone(c);
    checkOutput("t5_rrSum", 32'(sum), 32'h07);
    tick();

    // Inputs churn mid-add; result must reflect the operands captured at grant.
    a0 = 8'h3C; b0 = 8'h0F;
    req = 2'b01;
    tick();
    checkOutput("t6_ack", 32'(ack), 32'd1);
    c = 0;
    for (int i = 0; i < 40; i++) begin
      a0  = N'($urandom);
      b0  = N'($urandom);
      req = {~req[1], 1'b0};
      tick();
      c++;
      if (done) break;
      checkOutput("t6_noReAck", 32'(ack), 32'd0);
    end
    req = 2'b00;
    checkOutput("t6_latency", 32'(c), 32'(N));
    checkOutput("t6_sum", 32'(sum), 32'h4B);
    checkOutput("t6_cout", 32'(cout), 32'd0);
    checkOutput("t6_id", 32'(done_id), 32'd0);
    tick();
    tick();
    checkOutput("t6_idleAfter", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Controller that shares one bit-serial adder (a full adder with a registered carry) between two requesters. The requesters present N-bit operand pairs. The block arbitrates round-robin, latches the granted operands, and streams them LSB-first through the serial adder for N cycles. It then returns the N-bit sum and carry-out with a one-cycle done pulse. It sits between the requesting datapath blocks and the serial add resource, and is the only block that drives that resource.

## Interface
- N, default 8: operand/sum width in bits; N ≥ 2.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- req  in  2  req[i] high = requester i wants an add; held until ack[i].
- a0, b0  in  N each  requester 0 operands.
- a1, b1  in  N each  requester 1 operands.
- ack  out  2  one-hot, one-cycle pulse: operands of requester i were captured.
- busy  out  1  high while an add is in progress (RUN or DONE).
- done  out  1  one-cycle pulse: sum/cout valid.
- done_id  out  1  requester whose result is on sum/cout; valid while done=1.
- sum  out  N  a+b mod 2^N; valid while done=1.
- cout  out  1  carry out of bit N-1; valid while done=1.

## Operation
- States: IDLE, RUN, DONE.
- Round-robin pointer `last` (1 bit, id of last served requester):
  - Reset value is 1, so requester 0 wins first.
- IDLE:
  - req==00: stay in IDLE.
  - One request: grant it.
  - Both requests: grant requester !last.
- On the grant edge:
  - Load shift regs A,B from the winner's operands.
  - Sync-clear the adder carry.
  - cnt <= 0; last <= winner; ack[winner] <= 1.
  - Go to RUN.
- RUN, each edge:
  - The adder sums A[0], B[0] and the carry.
  - S <= {s, S[N-1:1]}; A,B shift right by one; carry updates; cnt++.
  - On the edge with cnt==N-1: cout_r <= adder carry-out; go to DONE.
- DONE:
  - done=1, sum=S, cout=cout_r, done_id=last.
  - Next edge goes to IDLE unconditionally.
  - Requests are not sampled in DONE.
- Operand inputs and req are ignored outside the IDLE grant edge. Changing them mid-add has no effect on the result.
- A requester still holding req after its ack is re-arbitrated as a new request.
- Outputs when done=0:
  - sum and cout are don't-care, but deterministic: sum = S, cout = cout_r.
  - done_id = last.
- Reset values: ack=00, busy=0, done=0, done_id=1, sum=0, cout=0; state IDLE; A, B, S, cnt, cout_r and carry all 0.
- Reset in any state (including mid-RUN) aborts the add. No done is issued, and the pointer returns to 1.

## Timing
- Let E0 be the IDLE edge that grants a request.
- ack is high in cycle E0+1, which is the first RUN cycle.
- Bits 0..N-1 are processed on edges E0+1..E0+N.
- done is high in the cycle after edge E0+N, i.e. N cycles after ack.
- busy is high from cycle E0+1 through the done cycle inclusive.
- Back-to-back throughput:
  - DONE → IDLE takes one edge, and IDLE grants on the next edge.
  - Consecutive done pulses are therefore N+2 cycles apart.
- Minimum request-to-done latency is N+1 cycles, counted from the cycle in which req is sampled in IDLE.

## Structure
- Shared package `serial_add_pkg` holds:
  - state enum `sa_state_t` {IDLE, RUN, DONE};
  - default width constant `SA_WIDTH = 8`.
- Sub-module `serial_adder_core`:
  - Ports: clk, reset, clr, en, x, y → s, c_next, c_q.
  - Contains one full adder and a carry DFF.
  - Carry DFF updates only when en=1; clr has priority over en.
  - The controller drives en=1 in RUN and clr=1 on the grant edge.
- The controller owns the FSM, round-robin pointer, bit counter ($clog2(N) bits), shift registers A/B/S and cout_r.

## Test plan
1. N=8, reset then req=01, a0=0x35, b0=0x4A → ack=01 one cycle later; done 8 cycles after ack; sum=0x7F, cout=0, done_id=0.
2. req0 with 0xFF+0x01 → sum=0x00, cout=1. Then 0x80+0x7F → sum=0xFF, cout=0, which checks that the carry is cleared between adds.
3. After reset, req=11 with 0x10+0x20 on requester 0 and 0x80+0x80 on requester 1 → requester 0 served first (sum=0x30, cout=0), then requester 1 (sum=0x00, cout=1); the two done pulses are exactly 10 cycles apart.
4. req held at 11 continuously → grants alternate 0,1,0,1; ack never asserted for two requesters at once; busy low exactly one cycle between adds.
5. reset pulsed during the 4th RUN cycle of 0xAA+0x55 → no done, busy=0 next cycle. A subsequent 0x01+0x01 from requester 1 → sum=0x02, cout=0, and requester 0 wins a later simultaneous request.
6. While busy, change a0/b0 every cycle and toggle req1 → result equals the operands captured at grant; ack is issued only in the first RUN cycle.
